// File: rtl/tick_scheduler_pkg.sv
// Shared types and constants for the tick scheduler.
//   chanState_t   : per-channel state (IDLE, RUN, DONE)
//   MODE_*        : cfgMode encodings
//   DEFAULT_*     : default counter width and input clock frequency
//   period_for_hz : cycles per tick for a wanted tick rate at DEFAULT_CLK_HZ
package tick_sched_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} chanState_t;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  localparam int          DEFAULT_CNT_W  = 28;
  localparam int unsigned DEFAULT_CLK_HZ = 32'd100_000_000;

  // A zero rate has no meaningful period; return 0, which a channel runs as P=1.
  function automatic int unsigned period_for_hz(input int unsigned hz);
    return (hz == 0) ? 32'd0 : DEFAULT_CLK_HZ / hz;
  endfunction

endpackage

// File: rtl/tick_scheduler_if.sv
// Configuration port of the tick scheduler (valid/ready, one request per accept).
//   cfgValid/cfgReady : handshake
//   cfgChan           : target channel
//   cfgPeriod         : period in clock cycles (0 runs as 1)
//   cfgMode           : 0 periodic, 1 one-shot
//   cfgEnable         : 1 start/restart, 0 stop
interface tick_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 28,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic             cfgValid;
  logic             cfgReady;
  logic [CH_W-1:0]  cfgChan;
  logic [CNT_W-1:0] cfgPeriod;
  logic             cfgMode;
  logic             cfgEnable;

  modport master (output cfgValid, cfgChan, cfgPeriod, cfgMode, cfgEnable,
                  input  cfgReady);
  modport slave  (input  cfgValid, cfgChan, cfgPeriod, cfgMode, cfgEnable,
                  output cfgReady);
endinterface

// File: rtl/tick_scheduler_channel.sv
// One tick channel: FSM, period counter, latched period/mode, tick and slow clock.
//   inClock, resetN : clock, async active-low reset
//   commit          : apply cmd* this edge (wins over a terminal count)
//   cmdEnable       : 1 -> RUN from any state, 0 -> IDLE
//   cmdMode         : MODE_PERIODIC / MODE_ONESHOT
//   cmdPeriod       : period, already mapped so that it is never 0
//   outTick         : one-cycle pulse each period (stays high for P=1)
//   outClock        : toggles on every tick
//   busy            : channel is in RUN
//
// state | meaning
// IDLE  | stopped, counter and outputs at 0
// RUN   | counting; tick on cnt == period-1
// DONE  | one-shot has fired; cnt and outClock hold until next commit
module tick_channel
  import tick_sched_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             inClock,
  input  logic             resetN,
  input  logic             commit,
  input  logic             cmdEnable,
  input  logic             cmdMode,
  input  logic [CNT_W-1:0] cmdPeriod,
  output logic             outTick,
  output logic             outClock,
  output logic             busy
);

  chanState_t       state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [CNT_W-1:0] period, periodNext;
  logic             mode, modeNext;
  logic             tickNext, clockNext;
  logic             termCount;

  // period is never 0, so period-1 cannot wrap.
  assign termCount = (cnt == period - CNT_W'(1));

  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    periodNext = period;
    modeNext   = mode;
    clockNext  = outClock;
    tickNext   = 1'b0;
    if (commit) begin
      periodNext = cmdPeriod;
      modeNext   = cmdMode;
      cntNext    = '0;
      clockNext  = 1'b0;
      stateNext  = cmdEnable ? RUN : IDLE;
    end else if (state == RUN) begin
      if (termCount) begin
        cntNext   = '0;
        tickNext  = 1'b1;
        clockNext = ~outClock;
        if (mode == MODE_ONESHOT) stateNext = DONE;
      end else begin
        cntNext = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge inClock or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE;
      cnt      <= '0;
      period   <= CNT_W'(1);
      mode     <= MODE_PERIODIC;
      outTick  <= 1'b0;
      outClock <= 1'b0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      period   <= periodNext;
      mode     <= modeNext;
      outTick  <= tickNext;
      outClock <= clockNext;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel clock-enable scheduler.
//   inClock, resetN : system clock, async active-low reset
//   cfg             : configuration port (tick_scheduler_if.slave)
//   outTick         : per-channel one-cycle enable pulse
//   outClock        : per-channel 50%-duty square wave (period 2P)
//   busy            : per-channel RUN indicator
// A request accepted on one edge is committed to its channel on the next;
// cfgReady drops for that commit cycle.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = DEFAULT_CNT_W,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              inClock,
  input  logic              resetN,
  tick_scheduler_if.slave   cfg,
  output logic [NUM_CH-1:0] outTick,
  output logic [NUM_CH-1:0] outClock,
  output logic [NUM_CH-1:0] busy
);

  localparam logic [CH_W:0] NUM_CH_V = (CH_W+1)'(NUM_CH);

  logic             readyQ;
  logic             acceptReq;
  logic             commitValid;
  logic [CH_W-1:0]  commitChan;
  logic [CNT_W-1:0] commitPeriod;
  logic             commitMode;
  logic             commitEnable;

  assign cfg.cfgReady = readyQ;
  assign acceptReq    = cfg.cfgValid && readyQ;

  always_ff @(posedge inClock or negedge resetN) begin
    if (!resetN) begin
      readyQ       <= 1'b0;
      commitValid  <= 1'b0;
      commitChan   <= '0;
      commitPeriod <= CNT_W'(1);
      commitMode   <= MODE_PERIODIC;
      commitEnable <= 1'b0;
    end else begin
      readyQ      <= !acceptReq;
      // Out-of-range channels are accepted but never committed.
      commitValid <= acceptReq && ({1'b0, cfg.cfgChan} < NUM_CH_V);
      if (acceptReq) begin
        commitChan   <= cfg.cfgChan;
        commitPeriod <= (cfg.cfgPeriod == '0) ? CNT_W'(1) : cfg.cfgPeriod;
        commitMode   <= cfg.cfgMode;
        commitEnable <= cfg.cfgEnable;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : gCh
    tick_channel #(.CNT_W(CNT_W)) uChan (
      .inClock   (inClock),
      .resetN    (resetN),
      .commit    (commitValid && (commitChan == CH_W'(i))),
      .cmdEnable (commitEnable),
      .cmdMode   (commitMode),
      .cmdPeriod (commitPeriod),
      .outTick   (outTick[i]),
      .outClock  (outClock[i]),
      .busy      (busy[i])
    );
  end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Multi-channel clock-enable scheduler for the 100 MHz system clock. It replaces per-consumer free-running divider counters with one controller that owns NUM_CH programmable tick channels. Each channel is configured at runtime through a single valid/ready port and produces a one-cycle enable pulse plus a 50%-duty slow square wave. Periodic and one-shot modes are supported. Consumers such as display refresh, debounce and 1 Hz timekeeping sit downstream of it.

## Interface
- CLK_HZ, 100000000: input clock frequency, documentation and test only.
- NUM_CH, 4: number of tick channels, 1..16.
- CNT_W, 28: period counter width (28 bits covers 1 Hz at 100 MHz).
- CH_W, $clog2(NUM_CH) (min 1): channel index width.
- inClock  in  1  system clock, 100 MHz; single clock domain.
- resetN  in  1  reset, asynchronous assert, active-low.
- cfgValid  in  1  config request valid.
- cfgReady  out  1  config port can accept.
- cfgChan  in  CH_W  target channel.
- cfgPeriod  in  CNT_W  period in inClock cycles.
- cfgMode  in  1  0 = periodic, 1 = one-shot.
- cfgEnable  in  1  1 = start/restart, 0 = stop.
- outTick  out  NUM_CH  one-cycle enable pulse per channel.
- outClock  out  NUM_CH  square wave per channel, toggles on every tick.
- busy  out  NUM_CH  channel is in RUN.

## Operation
- Config handshake:
  - A request is accepted on an edge where cfgValid && cfgReady.
  - Fields are latched on accept and committed on the next edge.
  - cfgReady is low during the commit cycle, so at most one accept every 2 cycles.
  - cfgChan >= NUM_CH: the request is accepted and dropped, with no state change.
- Period: cfgPeriod = 0 is treated as 1. The latched period is held per channel.
- Channel FSM: IDLE, RUN, DONE.
  - Commit with cfgEnable=1, from any state: go to RUN; cnt <= 0; outClock <= 0; outTick <= 0.
  - Commit with cfgEnable=0: go to IDLE; cnt <= 0; outClock <= 0; outTick <= 0.
  - In RUN, when cnt == P-1: cnt <= 0; outTick <= 1; outClock toggles. If mode is one-shot, go to DONE.
  - In RUN otherwise: cnt <= cnt+1; outTick <= 0.
  - In DONE: outTick <= 0; cnt and outClock hold. Only a commit leaves DONE.
- busy = (state == RUN).
- Counters never exceed P-1. Wrap from P-1 to 0 is exact, with no skipped or extra cycles.
- Channels are independent; a commit affects only its target channel.

## Timing
- Reset (resetN low): cfgReady=0, outTick=0, outClock=0, busy=0, all channels IDLE, cnt=0, latched periods=1.
- cfgReady rises on the first inClock edge after resetN deasserts.
- Reset mid-operation: all outputs go to their reset values immediately (asynchronous). Any in-flight commit is lost.
- Latency, accept at edge A:
  - Commit at edge A+1; busy rises at A+1.
  - First outTick is high in the cycle after edge A+1+P.
  - Subsequent ticks every P cycles.
- outClock period = 2P cycles.
- P=1: outTick stays high continuously and outClock toggles every cycle.
- Simultaneous commit and terminal count on the same channel: the commit wins and the tick is suppressed.
- One-shot: exactly one tick. busy falls on the same edge the tick is registered.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package tick_sched_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - mode constants MODE_PERIODIC=0, MODE_ONESHOT=1;
  - default CNT_W and CLK_HZ;
  - the helper function period_for_hz(hz) = CLK_HZ/hz.
- Sub-module tick_channel holds one channel's FSM, counter, latched period, tick and clock registers. It is instantiated NUM_CH times in a generate loop.
- The top level holds the config handshake, commit register and channel decode.

## Test plan
- Reset, then accept ch0 with P=4, periodic, enable → busy[0] at A+1; outTick[0] pulses at A+5, A+9, A+13; outClock[0] 0→1→0 with an 8-cycle period.
- Ch1 with P=3, one-shot → exactly one outTick[1] at A+4; busy[1] falls on that edge; no further ticks over 50 cycles.
- Back-to-back cfgValid held high for 3 requests → accepts on alternate cycles only; cfgReady toggles 1,0,1,0.
- Ch2 running at P=10, then restart commit at cnt=9 (the terminal-count edge) → no tick; first new tick 10 cycles after the commit; outClock[2] forced to 0.
- cfgPeriod=0 on ch3 → outTick[3] high continuously; outClock[3] toggles each cycle. Then stop commit → all ch3 outputs 0 on the next edge.
- Assert resetN low mid-run with all channels busy → all outputs 0 asynchronously. After release, cfgReady=1 one edge later and no ticks appear until reconfigured.
